// File: rtl/encode_acc_requant_if.sv
// encode_acc_requant_if: product-in / result-out stream bundle for the encoder MAC tail.
interface encode_acc_requant_if #(
   parameter int IN_WIDTH   = 69,
   parameter int BIAS_WIDTH = 40,
   parameter int OUT_WIDTH  = 32
);
   logic                         in_valid, in_ready, in_last;
   logic signed [IN_WIDTH-1:0]   in_data;
   logic signed [BIAS_WIDTH-1:0] bias;
   logic                         out_valid, out_ready, out_sat, out_ovf;
   logic signed [OUT_WIDTH-1:0]  out_data;
   modport master (
      output in_valid, in_data, in_last, bias, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_ovf
   );
   modport slave (
      input  in_valid, in_data, in_last, bias, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_ovf
   );
endinterface

// File: rtl/encode_acc_requant.sv
// encode_acc_requant: accumulates signed products with a per-group bias, then round-shifts
// and saturates each group sum onto a valid/ready result port.
module encode_acc_requant #(
   parameter int IN_WIDTH   = 69,
   parameter int ACC_WIDTH  = 80,
   parameter int BIAS_WIDTH = 40,
   parameter int OUT_WIDTH  = 32,
   parameter int SHIFT      = 24,
   parameter int MAX_TERMS  = 1024
) (
   input logic               clk,
   input logic               reset,
   encode_acc_requant_if.slave bus
);
   localparam int CW = $clog2(MAX_TERMS + 1);
   localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
   localparam logic signed [ACC_WIDTH:0] OMAX = {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] OMIN = {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {ACC, ROUND, HOLD} state_t;
   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc, base, term;
   logic signed [ACC_WIDTH:0]   sum, r;
   logic [CW-1:0]               cnt;
   logic                        first, ovf, sat_hi, sat_lo, hit;
   always_comb begin
      term   = {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
      base   = first ? {{(ACC_WIDTH-BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias} : acc;
      sum    = {acc[ACC_WIDTH-1], acc} + HALF;
      r      = sum >>> SHIFT;
      sat_hi = r > OMAX;
      sat_lo = r < OMIN;
      hit    = cnt == CW'(MAX_TERMS - 1);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= ACC;
         acc           <= '0;
         cnt           <= '0;
         first         <= 1'b0;
         ovf           <= 1'b0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sat   <= 1'b0;
         bus.out_ovf   <= 1'b0;
      end else
         case (state)
            ACC:
               // in_ready is low in ACC only on the first cycle after reset release
               if (!bus.in_ready) begin
                  bus.in_ready <= 1'b1;
                  first        <= 1'b1;
               end else if (bus.in_valid) begin
                  acc   <= base + term;
                  first <= 1'b0;
                  cnt   <= cnt + 1'b1;
                  if (bus.in_last || hit) begin
                     ovf          <= hit & !bus.in_last;
                     bus.in_ready <= 1'b0;
                     state        <= ROUND;
                  end
               end
            ROUND: begin
               bus.out_data  <= sat_hi ? OMAX[OUT_WIDTH-1:0] : sat_lo ? OMIN[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
               bus.out_sat   <= sat_hi | sat_lo;
               bus.out_ovf   <= ovf;
               bus.out_valid <= 1'b1;
               state         <= HOLD;
            end
            default:
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  acc           <= '0;
                  cnt           <= '0;
                  ovf           <= 1'b0;
                  first         <= 1'b1;
                  state         <= ACC;
               end
         endcase
endmodule

// File: tb/tb_encode_acc_requant.sv
// tb_encode_acc_requant: directed stimulus with an expected-result queue checked at each
// output handshake; the DUT runs with MAX_TERMS = 4 so force-close is reachable.
module tb_encode_acc_requant;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   typedef struct packed {
      logic [31:0] d;
      logic        s;
      logic        o;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   encode_acc_requant_if #(.IN_WIDTH(69), .BIAS_WIDTH(40), .OUT_WIDTH(32)) bus ();
   encode_acc_requant #(.MAX_TERMS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   // result handshake happens at the next rising edge when both are high here
   always @(negedge clk)
      if (reset && bus.out_valid && bus.out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_out got=%h expected none", bus.out_data);
         end
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            assert (bus.out_data === e.d) else begin
               errors++;
               $error("FAIL out_data got=%h expected=%h", bus.out_data, e.d);
            end
            assert (bus.out_sat === e.s) else begin
               errors++;
               $error("FAIL out_sat got=%b expected=%b", bus.out_sat, e.s);
            end
            assert (bus.out_ovf === e.o) else begin
               errors++;
               $error("FAIL out_ovf got=%b expected=%b", bus.out_ovf, e.o);
            end
         end
      end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic [68:0] d, input logic l, input logic [39:0] b);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.bias     = b;
      forever begin
         @(negedge clk);
         if (bus.in_ready || n >= 50) break;
         n++;
      end
      chk("beat_accept_timeout", 32'(n < 50), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_remaining", 32'(q.size()), 32'd0);
   endtask
   initial begin
      bus.in_valid  = 1'b1;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.bias      = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
      // single term 3.5 -> 4, with cycle-exact latency checks
      q.push_back('{32'd4, 1'b0, 1'b0});
      beat(69'h3800000, 1'b1, 40'h0);
      chk("round_out_valid", 32'(bus.out_valid), 32'd0);
      chk("round_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      tick();
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      q.push_back('{32'hFFFFFFFF, 1'b0, 1'b0});
      beat(-69'sh1800000, 1'b1, 40'h0);
      q.push_back('{32'd1, 1'b0, 1'b0});
      beat(69'h800000, 1'b1, 40'h0);
      q.push_back('{32'd0, 1'b0, 1'b0});
      beat(-69'sh800000, 1'b1, 40'h0);
      drain();
      // biased multi-term, back-to-back then with gaps
      q.push_back('{32'd5, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) beat(69'h1000000, 1'(i == 3), 40'h1000000);
      drain();
      q.push_back('{32'd5, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) begin
         beat(69'h1000000, 1'(i == 3), 40'h1000000);
         if (i != 3) repeat (2) tick();
      end
      drain();
      // saturation edges
      q.push_back('{32'h7FFFFFFF, 1'b0, 1'b0});
      beat(69'h7FFFFFFF000000, 1'b1, 40'h0);
      q.push_back('{32'h7FFFFFFF, 1'b1, 1'b0});
      beat({1'b0, {68{1'b1}}}, 1'b1, 40'h0);
      q.push_back('{32'h80000000, 1'b1, 1'b0});
      beat({1'b1, 68'h0}, 1'b1, 40'h0);
      drain();
      // backpressure: beats offered while holding must not be absorbed
      bus.out_ready = 1'b0;
      q.push_back('{32'd2, 1'b0, 1'b0});
      beat(69'h2000000, 1'b1, 40'h0);
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 69'h7000000;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_data", bus.out_data, 32'd2);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      q.push_back('{32'd1, 1'b0, 1'b0});
      beat(69'h1000000, 1'b1, 40'h0);
      drain();
      // force-close at 4 terms; the 5th beat opens the next group
      q.push_back('{32'd4, 1'b0, 1'b1});
      q.push_back('{32'd1, 1'b0, 1'b0});
      for (int i = 0; i < 5; i++) beat(69'h1000000, 1'(i == 4), 40'h0);
      drain();
      // mid-group reset discards the partial sum
      beat(69'h1000000, 1'b0, 40'h3000000);
      beat(69'h1000000, 1'b0, 40'h3000000);
      reset = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      q.push_back('{32'd1, 1'b0, 1'b0});
      beat(69'h1000000, 1'b1, 40'h0);
      drain();
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
